// File: rtl/mul4_shift_add.sv
// Sequential 4x4 unsigned shift-and-add multiplier that borrows an external 4-bit adder.
// One add-and-shift iteration per clock, four iterations per product, start/busy/done handshake.
module mul4_shift_add #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [WIDTH-1:0]   add_a,
   output logic [WIDTH-1:0]   add_b,
   output logic               add_ci,
   input  logic [WIDTH-1:0]   add_sum,
   input  logic               add_cout,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [2:0] LAST_ITER = 3'(WIDTH - 1);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic [2:0]           cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [2*WIDTH-1:0]   shifted_s;

   // The adder carry-out becomes acc[MSB], so no carry is ever dropped.
   assign shifted_s = {add_cout, add_sum, q_q[WIDTH-1:1]};

   // Adder operands are held at zero outside RUN so the shared adder stays quiet.
   assign add_a  = (state_q == ST_RUN) ? acc_q : {WIDTH{1'b0}};
   assign add_b  = ((state_q == ST_RUN) && q_q[0]) ? m_q : {WIDTH{1'b0}};
   assign add_ci = 1'b0;

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

   // Next-state and datapath update for the IDLE -> RUN x4 -> DONE sequence.
   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      acc_d     = acc_q;
      q_d       = q_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               m_d     = a;
               q_d     = b;
               acc_d   = {WIDTH{1'b0}};
               cnt_d   = 3'd0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            {acc_d, q_d} = shifted_s;
            cnt_d        = cnt_q + 3'd1;
            if (cnt_q == LAST_ITER) begin
               product_d = shifted_s;
               state_d   = ST_DONE;
            end else begin
               state_d   = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         m_q       <= {WIDTH{1'b0}};
         acc_q     <= {WIDTH{1'b0}};
         q_q       <= {WIDTH{1'b0}};
         cnt_q     <= 3'd0;
         product_q <= {(2*WIDTH){1'b0}};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_mul4_shift_add.sv
// Directed and table-driven bench for mul4_shift_add; models the external 4-bit adder.
module tb_mul4_shift_add;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] a = 4'd0;
   logic [3:0] b = 4'd0;
   logic [3:0] add_a;
   logic [3:0] add_b;
   logic       add_ci;
   logic [3:0] add_sum;
   logic       add_cout;
   logic       busy;
   logic       done;
   logic [7:0] product;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] p;
   } vec_t;

   vec_t vecs [11];

   int         total = 0;
   int         passed = 0;
   int         lat;
   int         width;
   int         run_n;
   logic       saw_cout;
   logic       b_quiet;
   logic       first_busy;
   logic       aborted_done;
   logic [3:0] run_a [4];
   logic [3:0] run_b [4];

   always #5 clk = ~clk;

   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_ci};

   mul4_shift_add #(.WIDTH(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .a        (a),
      .b        (b),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_ci   (add_ci),
      .add_sum  (add_sum),
      .add_cout (add_cout),
      .busy     (busy),
      .done     (done),
      .product  (product)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic start_op(input logic [3:0] av, input logic [3:0] bv);
      @(negedge clk);
      a = av;
      b = bv;
      start = 1'b1;
   endtask

   // Watches one operation from the cycle after acceptance until done drops.
   task automatic wait_done(input bit hold, input logic [3:0] na, input logic [3:0] nb);
      lat = 0;
      width = 0;
      run_n = 0;
      saw_cout = 1'b0;
      b_quiet = 1'b1;
      first_busy = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c == 1) begin
            first_busy = busy;
            a = na;
            b = nb;
            if (!hold) start = 1'b0;
         end
         if (busy && !done) begin
            if (run_n < 4) begin
               run_a[run_n] = add_a;
               run_b[run_n] = add_b;
            end
            run_n++;
            if (add_cout) saw_cout = 1'b1;
            if (add_b != 4'd0) b_quiet = 1'b0;
         end
         if (done) begin
            if (lat == 0) lat = c;
            width++;
         end else if (lat != 0) begin
            break;
         end
      end
   endtask

   initial begin
      vecs[0]  = '{4'd3,  4'd5,  8'd15};
      vecs[1]  = '{4'd15, 4'd15, 8'd225};
      vecs[2]  = '{4'd0,  4'd9,  8'd0};
      vecs[3]  = '{4'd9,  4'd0,  8'd0};
      vecs[4]  = '{4'd1,  4'd1,  8'd1};
      vecs[5]  = '{4'd15, 4'd1,  8'd15};
      vecs[6]  = '{4'd1,  4'd15, 8'd15};
      vecs[7]  = '{4'd8,  4'd8,  8'd64};
      vecs[8]  = '{4'd10, 4'd12, 8'd120};
      vecs[9]  = '{4'd7,  4'd9,  8'd63};
      vecs[10] = '{4'd12, 4'd11, 8'd132};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_product", 32'(product), 32'd0);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_done",    32'(done),    32'd0);
      check("rst_add_a",   32'(add_a),   32'd0);
      check("rst_add_b",   32'(add_b),   32'd0);
      check("rst_add_ci",  32'(add_ci),  32'd0);
      reset = 1'b0;

      // 3 * 5 with latency, pulse width and hold checks
      start_op(4'd3, 4'd5);
      wait_done(1'b0, 4'd10, 4'd10);
      check("t1_busy_rise", 32'(first_busy), 32'd1);
      check("t1_latency",   32'(lat),        32'd5);
      check("t1_done_width",32'(width),      32'd1);
      check("t1_run_cycles",32'(run_n),      32'd4);
      check("t1_product",   32'(product),    32'd15);
      repeat (3) @(negedge clk);
      check("t1_hold",      32'(product),    32'd15);
      check("t1_idle_busy", 32'(busy),       32'd0);
      check("t1_idle_add_a",32'(add_a),      32'd0);
      check("t1_idle_add_b",32'(add_b),      32'd0);

      // 15 * 15: carry into acc MSB, acc=7 after first iteration
      start_op(4'd15, 4'd15);
      wait_done(1'b0, 4'd0, 4'd0);
      check("t2_product",   32'(product),  32'd225);
      check("t2_saw_cout",  32'(saw_cout), 32'd1);
      check("t2_iter0_a",   32'(run_a[0]), 32'd0);
      check("t2_iter1_a",   32'(run_a[1]), 32'd7);
      check("t2_iter1_b",   32'(run_b[1]), 32'd15);

      // Zero operands
      start_op(4'd0, 4'd9);
      wait_done(1'b0, 4'd5, 4'd5);
      check("t3_0x9", 32'(product), 32'd0);
      start_op(4'd9, 4'd0);
      wait_done(1'b0, 4'd5, 4'd5);
      check("t3_9x0",       32'(product), 32'd0);
      check("t3_b_quiet",   32'(b_quiet), 32'd1);
      check("t3_run_cycles",32'(run_n),   32'd4);

      // start held through RUN/DONE with changed operands
      start_op(4'd2, 4'd3);
      wait_done(1'b1, 4'd7, 4'd7);
      check("t4_first_product", 32'(product), 32'd6);
      check("t4_first_width",   32'(width),   32'd1);
      wait_done(1'b0, 4'd1, 4'd1);
      check("t4_second_latency",32'(lat),     32'd5);
      check("t4_second_product",32'(product), 32'd49);

      // Asynchronous reset during the second RUN cycle
      start_op(4'd12, 4'd11);
      @(negedge clk);
      start = 1'b0;
      a = 4'd0;
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("t5_abort_product", 32'(product), 32'd0);
      check("t5_abort_busy",    32'(busy),    32'd0);
      check("t5_abort_done",    32'(done),    32'd0);
      check("t5_abort_add_a",   32'(add_a),   32'd0);
      @(negedge clk);
      reset = 1'b0;
      aborted_done = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (done || busy) aborted_done = 1'b1;
      end
      check("t5_no_done", 32'(aborted_done), 32'd0);
      start_op(4'd12, 4'd11);
      wait_done(1'b0, 4'd3, 4'd3);
      check("t5_restart_product", 32'(product), 32'd132);
      check("t5_restart_latency", 32'(lat),     32'd5);

      // Table-driven directed vectors
      for (int i = 0; i < 11; i++) begin
         start_op(vecs[i].a, vecs[i].b);
         wait_done(1'b0, ~vecs[i].a, ~vecs[i].b);
         check($sformatf("vec%0d_product", i), 32'(product), 32'(vecs[i].p));
         check($sformatf("vec%0d_width", i),   32'(width),   32'd1);
      end

      // Exhaustive sweep against a*b
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            start_op(4'(ai), 4'(bi));
            wait_done(1'b0, 4'(bi), 4'(ai));
            check($sformatf("sweep_%0dx%0d", ai, bi), 32'(product), 32'(ai * bi));
            check($sformatf("sweep_%0dx%0d_width", ai, bi), 32'(width), 32'd1);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
